mem_stage: RTL and testbench

- Memory stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM register outputs (ALUResultM, WriteDataM, PCPlus4M, RdM and the control signals).
- Performs byte/half/word loads and stores against a byte-addressed, little-endian data memory, then registers the results into the MEM/WB pipeline register for writeback.
- Owns the MEM/WB stall/flush semantics and flags misaligned accesses.

---
 rtl/pipeline_pkg.sv | 49 ++++
 rtl/data_mem.sv | 44 ++++
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the RISC-V pipeline memory stage:
//   - AddrMode (funct3) codes for byte/half/word, signed/unsigned accesses
//   - byte-offset width and lane count of the 32-bit data memory word
//   - a decoded access descriptor and the function that builds it
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int OFFSET_W = 2;  // byte offset inside a 32-bit word
  localparam int LANES    = 4;  // byte lanes per memory word

  localparam logic [2:0] ADDR_B  = 3'b000;  // LB / SB
  localparam logic [2:0] ADDR_H  = 3'b001;  // LH / SH
  localparam logic [2:0] ADDR_W  = 3'b010;  // LW / SW
  localparam logic [2:0] ADDR_BU = 3'b100;  // LBU
  localparam logic [2:0] ADDR_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    size_e size;      // access width
    logic  sign_ext;  // sign-extend loaded byte/half
    logic  illegal;   // unused funct3 code
  } mode_t;

  // Illegal codes decode as word-sized so the address path behaves like LW/SW;
  // the illegal bit then forces the misalignment flag.
  function automatic mode_t decode_mode(input logic [2:0] mode);
    mode_t d;
    d.size     = SIZE_WORD;
    d.sign_ext = 1'b0;
    d.illegal  = 1'b0;
    case (mode)
      ADDR_B:  begin d.size = SIZE_BYTE; d.sign_ext = 1'b1; end
      ADDR_H:  begin d.size = SIZE_HALF; d.sign_ext = 1'b1; end
      ADDR_W:  d.size = SIZE_WORD;
      ADDR_BU: d.size = SIZE_BYTE;
      ADDR_HU: d.size = SIZE_HALF;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-organised data memory with per-byte write enables.
//   clk      : write clock
//   rst_n    : asynchronous active-low reset; suppresses writes while low
//   i_we     : write enable (already qualified by the caller)
//   i_be     : byte-lane enables, lane 0 = bits [7:0]
//   i_idx    : word index
//   i_wdata  : write data, each lane in its final position
//   o_rdata  : combinational read of word i_idx
// -----------------------------------------------------------------------------
module data_mem
  import pipeline_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [LANES-1:0]     i_be,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [8*LANES-1:0]   i_wdata,
  output logic [8*LANES-1:0]   o_rdata
);

  logic [LANES-1:0][7:0] r_mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch on purpose; clearing a RAM would
  // prevent block-RAM mapping. rst_n is only used as a write qualifier so a
  // store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && i_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][b] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage RISC-V pipeline plus the MEM/WB register.
//   Inputs (M stage): ALUResultM (byte address), WriteDataM (store data),
//     PCPlus4M, RdM, RegWriteM, ResultSrcM (load), MemWriteM (store),
//     AddrModeM (funct3), WD3SrcM, StallW / FlushW (MEM/WB control).
//   Outputs (W stage): ReadDataW (formatted load data), ALUResultW, PCPlus4W,
//     RdW, RegWriteW (suppressed for misaligned loads), ResultSrcW, WD3SrcW,
//     MisalignW.
// Little-endian, byte addressed; addresses wrap modulo DEPTH_WORDS*4.
// -----------------------------------------------------------------------------
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [WIDTH-1:0] PCPlus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             ResultSrcM,
  input  logic             MemWriteM,
  input  logic [2:0]       AddrModeM,
  input  logic             WD3SrcM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic             WD3SrcW,
  output logic             MisalignW
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mode_t               w_mode;
  logic [OFFSET_W-1:0] w_off;
  logic [IDX_W-1:0]    w_idx;
  logic                w_misalign;
  logic                w_mem_we;
  logic [LANES-1:0]    w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rword;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [WIDTH-1:0]    w_load_data;
  logic                w_unused_addr;

  assign w_mode = decode_mode(AddrModeM);
  assign w_off  = ALUResultM[OFFSET_W-1:0];
  assign w_idx  = ALUResultM[IDX_W+OFFSET_W-1:OFFSET_W];

  // Upper address bits are intentionally ignored (address wrap).
  assign w_unused_addr = ^ALUResultM[WIDTH-1:IDX_W+OFFSET_W];

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_misalign = 1'b0;
    if (MemWriteM || ResultSrcM) begin
      case (w_mode.size)
        SIZE_HALF: w_misalign = w_off[0];
        SIZE_WORD: w_misalign = (w_off != '0);
        default:   w_misalign = 1'b0;
      endcase
      if (w_mode.illegal) begin
        w_misalign = 1'b1;
      end
    end
  end

  // Replicating the byte/half across the word puts it on every candidate lane;
  // the byte enables then pick the lane(s) actually written.
  always_comb begin
    w_be    = '0;
    w_wdata = WriteDataM[31:0];
    case (w_mode.size)
      SIZE_BYTE: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      SIZE_HALF: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
  end

  // Stalled stores are held in M and would otherwise be written again on
  // every stalled edge.
  assign w_mem_we = MemWriteM & ~w_misalign & ~StallW;

  data_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_data_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_be    (w_be),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rword)
  );

  // Shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    w_byte      = w_rword[{w_off, 3'b000} +: 8];
    w_half      = w_rword[{w_off[1], 4'b0000} +: 16];
    w_load_data = '0;
    if (!w_misalign) begin
      case (w_mode.size)
        SIZE_BYTE: w_load_data = {{(WIDTH-8){w_mode.sign_ext & w_byte[7]}}, w_byte};
        SIZE_HALF: w_load_data = {{(WIDTH-16){w_mode.sign_ext & w_half[15]}}, w_half};
        default:   w_load_data = WIDTH'(w_rword);
      endcase
    end
  end

  // MEM/WB register: flush wins over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadDataW  <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      WD3SrcW    <= 1'b0;
      MisalignW  <= 1'b0;
    end else if (FlushW) begin
      ReadDataW  <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      WD3SrcW    <= 1'b0;
      MisalignW  <= 1'b0;
    end else if (!StallW) begin
      ReadDataW  <= w_load_data;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~(ResultSrcM & w_misalign);
      ResultSrcW <= ResultSrcM;
      WD3SrcW    <= WD3SrcM;
      MisalignW  <= w_misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: directed scenarios with literal expected
// values, plus randomized traffic against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import pipeline_pkg::*;

  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, MemWriteM, WD3SrcM, StallW, FlushW;
  logic [2:0]  AddrModeM;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, ResultSrcW, WD3SrcW, MisalignW;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0]  mm [0:MEM_BYTES-1];
  logic [31:0] e_rd, e_alu, e_pc;
  logic [4:0]  e_rdw;
  logic        e_rw, e_rs, e_wd3, e_mis;

  mem_stage #(.WIDTH(32), .DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .AddrModeM  (AddrModeM),
    .WD3SrcM    (WD3SrcM),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .WD3SrcW    (WD3SrcW),
    .MisalignW  (MisalignW)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned msize(input logic [2:0] m);
    case (m)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] m);
    return (m == 3'b011) || (m == 3'b110) || (m == 3'b111);
  endfunction

  function automatic logic [31:0] model_read(input int unsigned a, input logic [2:0] m);
    int unsigned sz;
    int unsigned base;
    logic [31:0] v;
    sz   = msize(m);
    base = a - (a % sz);
    v    = 32'h0;
    for (int i = 0; i < int'(sz); i++) v = v | (32'(mm[base + i]) << (8 * i));
    if (!m[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic model_clear();
    e_rd = 0; e_alu = 0; e_pc = 0; e_rdw = 0;
    e_rw = 0; e_rs = 0; e_wd3 = 0; e_mis = 0;
  endtask

  // Computes what the next clock edge does with the current M-stage inputs.
  task automatic model_edge();
    int unsigned a, sz;
    logic        mis;
    logic [31:0] rv;
    a   = ALUResultM % MEM_BYTES;
    sz  = msize(AddrModeM);
    mis = (MemWriteM || ResultSrcM) && (is_illegal(AddrModeM) || (a % sz) != 0);
    rv  = mis ? 32'h0 : model_read(a, AddrModeM);
    if (rst_n && MemWriteM && !mis && !StallW)
      for (int i = 0; i < int'(sz); i++) mm[a + i] = WriteDataM[8*i +: 8];
    if (!rst_n || FlushW) model_clear();
    else if (!StallW) begin
      e_rd = rv; e_alu = ALUResultM; e_pc = PCPlus4M; e_rdw = RdM;
      e_rw = RegWriteM && !(ResultSrcM && mis);
      e_rs = ResultSrcM; e_wd3 = WD3SrcM; e_mis = mis;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] mode,
                       input logic mw, input logic rs, input logic rw, input logic [4:0] rd,
                       input logic stall, input logic flush);
    ALUResultM = addr; WriteDataM = wd; AddrModeM = mode;
    MemWriteM = mw; ResultSrcM = rs; RegWriteM = rw; RdM = rd;
    StallW = stall; FlushW = flush;
    PCPlus4M = $urandom(); WD3SrcM = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] mode);
    drive(addr, wd, mode, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic ld(input logic [31:0] addr, input logic [2:0] mode, input logic [4:0] rd);
    drive(addr, 32'h0, mode, 1'b0, 1'b1, 1'b1, rd, 1'b0, 1'b0);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    drive(32'h0000_1234, 32'h0, ADDR_W, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({ReadDataW, ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW, WD3SrcW, MisalignW} !== '0) begin
      failures++;
      $display("FAIL reset_async outputs got rd=%h alu=%h pc=%h rdw=%0d rw=%b want all 0",
               ReadDataW, ALUResultW, PCPlus4W, RdW, RegWriteW);
    end
    model_clear();
    tick();
    tick();
    checks++;
    if ({ALUResultW, RdW, RegWriteW} !== '0) begin
      failures++;
      $display("FAIL reset_held alu=%h rdw=%0d rw=%b want 0", ALUResultW, RdW, RegWriteW);
    end
    #3 rst_n = 1'b1;
    drive(32'h0000_1234, 32'h0, ADDR_W, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    checks++;
    if (RdW !== 5'd3 || RegWriteW !== 1'b1 || ALUResultW !== 32'h0000_1234) begin
      failures++;
      $display("FAIL reset_release rdw=%0d rw=%b alu=%h want 3 1 00001234", RdW, RegWriteW, ALUResultW);
    end
  endtask

  task automatic init_memory();
    for (int w = 0; w < MEM_BYTES / 4; w++) st(32'(w * 4), $urandom(), ADDR_W);
  endtask

  task automatic test_reset_midstream();
    st(32'h40, 32'h0BAD_BEEF, ADDR_W);
    ld(32'h40, ADDR_W, 5'd3);
    checks++;
    if (RegWriteW !== 1'b1 || ReadDataW !== 32'h0BAD_BEEF) begin
      failures++;
      $display("FAIL mid_pre rw=%b rd=%h want 1 0badbeef", RegWriteW, ReadDataW);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ReadDataW, ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW, WD3SrcW, MisalignW} !== '0) begin
      failures++;
      $display("FAIL mid_async rd=%h alu=%h rdw=%0d rw=%b want all 0", ReadDataW, ALUResultW, RdW, RegWriteW);
    end
    model_clear();
    drive(32'h40, 32'hCAFE_F00D, ADDR_W, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    ld(32'h40, ADDR_W, 5'd4);
    checks++;
    if (ReadDataW !== 32'h0BAD_BEEF || RdW !== 5'd4 || RegWriteW !== 1'b1) begin
      failures++;
      $display("FAIL mid_store_in_reset rd=%h rdw=%0d rw=%b want 0badbeef 4 1", ReadDataW, RdW, RegWriteW);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  modes [5] = '{ADDR_B, ADDR_BU, ADDR_H, ADDR_HU, ADDR_W};
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] wants [5] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_DEAD, 32'hDEAD_BEEF};
    st(32'h10, 32'hDEAD_BEEF, ADDR_W);
    for (int i = 0; i < 5; i++) begin
      ld(addrs[i], modes[i], 5'(i + 1));
      checks++;
      if (ReadDataW !== wants[i] || RdW !== 5'(i + 1) || MisalignW !== 1'b0) begin
        failures++;
        $display("FAIL load[%0d] mode=%b rd=%h rdw=%0d mis=%b want %h", i, modes[i], ReadDataW, RdW, MisalignW, wants[i]);
      end
    end
    st(32'h11, 32'hFFFF_FF55, ADDR_B);
    ld(32'h10, ADDR_W, 5'd6);
    checks++;
    if (ReadDataW !== 32'hDEAD_55EF) begin
      failures++;
      $display("FAIL sb_then_lw rd=%h want dead55ef", ReadDataW);
    end
    st(32'h12, 32'h0000_1357, ADDR_H);
    ld(32'h10, ADDR_W, 5'd6);
    checks++;
    if (ReadDataW !== 32'h1357_55EF) begin
      failures++;
      $display("FAIL sh_then_lw rd=%h want 135755ef", ReadDataW);
    end
  endtask

  task automatic test_misalign();
    st(32'h20, 32'h1122_3344, ADDR_W);
    st(32'h21, 32'h0000_BEEF, ADDR_H);
    ld(32'h20, ADDR_W, 5'd5);
    checks++;
    if (ReadDataW !== 32'h1122_3344) begin
      failures++;
      $display("FAIL mis_store_suppressed rd=%h want 11223344", ReadDataW);
    end
    ld(32'h22, ADDR_W, 5'd5);
    checks++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || RdW !== 5'd5) begin
      failures++;
      $display("FAIL mis_lw mis=%b rw=%b rd=%h rdw=%0d want 1 0 0 5", MisalignW, RegWriteW, ReadDataW, RdW);
    end
    ld(32'h20, 3'b011, 5'd5);
    checks++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin
      failures++;
      $display("FAIL mis_illegal mis=%b rw=%b want 1 0", MisalignW, RegWriteW);
    end
  endtask

  task automatic test_stall();
    st(32'h30, 32'hAAAA_0000, ADDR_W);
    st(32'h38, 32'h0, ADDR_W);
    ld(32'h38, ADDR_W, 5'd7);
    for (int i = 0; i < 3; i++) begin
      drive(32'h30, 32'h1, ADDR_W, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if (RdW !== 5'd7 || RegWriteW !== 1'b1 || ResultSrcW !== 1'b1 || ReadDataW !== 32'h0 || ALUResultW !== 32'h38) begin
        failures++;
        $display("FAIL stall_hold[%0d] rdw=%0d rw=%b rs=%b rd=%h alu=%h want 7 1 1 0 38",
                 i, RdW, RegWriteW, ResultSrcW, ReadDataW, ALUResultW);
      end
    end
    st(32'h30, 32'h1, ADDR_W);
    st(32'h34, 32'h2, ADDR_W);
    ld(32'h30, ADDR_W, 5'd8);
    checks++;
    if (ReadDataW !== 32'h1) begin
      failures++;
      $display("FAIL stall_store rd=%h want 00000001", ReadDataW);
    end
    drive(32'h38, 32'h99, ADDR_W, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    ld(32'h38, ADDR_W, 5'd8);
    checks++;
    if (ReadDataW !== 32'h0) begin
      failures++;
      $display("FAIL stall_blocks_write rd=%h want 0", ReadDataW);
    end
  endtask

  task automatic test_flush_wrap();
    ld(32'h30, ADDR_W, 5'd9);
    drive(32'h30, 32'h0, ADDR_W, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
    tick();
    checks++;
    if (RegWriteW !== 1'b0 || RdW !== 5'd0 || ReadDataW !== 32'h0 || MisalignW !== 1'b0 || ResultSrcW !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble rw=%b rdw=%0d rd=%h mis=%b rs=%b want 0", RegWriteW, RdW, ReadDataW, MisalignW, ResultSrcW);
    end
    drive(32'h30, 32'h77, ADDR_W, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    ld(32'h30, ADDR_W, 5'd9);
    checks++;
    if (ReadDataW !== 32'h1) begin
      failures++;
      $display("FAIL flush_stall_store rd=%h want 00000001", ReadDataW);
    end
    st(32'h1000, 32'h1234_5678, ADDR_W);
    ld(32'h0, ADDR_W, 5'd10);
    checks++;
    if (ReadDataW !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wrap_lw rd=%h want 12345678", ReadDataW);
    end
    ld(32'h2002, ADDR_HU, 5'd10);
    checks++;
    if (ReadDataW !== 32'h0000_1234) begin
      failures++;
      $display("FAIL wrap_lhu rd=%h want 00001234", ReadDataW);
    end
  endtask

  task automatic test_random();
    logic [2:0]  legal [5] = '{ADDR_B, ADDR_H, ADDR_W, ADDR_BU, ADDR_HU};
    logic [2:0]  mode;
    logic [31:0] addr;
    logic        mw, rs;
    for (int i = 0; i < 500; i++) begin
      mode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      addr = $urandom() & 32'h0000_7FFF;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(msize(mode)) - 1);
      case ($urandom_range(0, 2))
        0:       begin mw = 1'b1; rs = 1'b0; end
        1:       begin mw = 1'b0; rs = 1'b1; end
        default: begin mw = 1'b0; rs = 1'b0; end
      endcase
      drive(addr, $urandom(), mode, mw, rs, 1'($urandom_range(0, 1)), 5'($urandom()),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      tick();
      checks += 8;
      if (ReadDataW !== e_rd) begin failures++; $display("FAIL rnd[%0d] ReadDataW got=%h want=%h", i, ReadDataW, e_rd); end
      if (ALUResultW !== e_alu) begin failures++; $display("FAIL rnd[%0d] ALUResultW got=%h want=%h", i, ALUResultW, e_alu); end
      if (PCPlus4W !== e_pc) begin failures++; $display("FAIL rnd[%0d] PCPlus4W got=%h want=%h", i, PCPlus4W, e_pc); end
      if (RdW !== e_rdw) begin failures++; $display("FAIL rnd[%0d] RdW got=%0d want=%0d", i, RdW, e_rdw); end
      if (RegWriteW !== e_rw) begin failures++; $display("FAIL rnd[%0d] RegWriteW got=%b want=%b", i, RegWriteW, e_rw); end
      if (ResultSrcW !== e_rs) begin failures++; $display("FAIL rnd[%0d] ResultSrcW got=%b want=%b", i, ResultSrcW, e_rs); end
      if (WD3SrcW !== e_wd3) begin failures++; $display("FAIL rnd[%0d] WD3SrcW got=%b want=%b", i, WD3SrcW, e_wd3); end
      if (MisalignW !== e_mis) begin failures++; $display("FAIL rnd[%0d] MisalignW got=%b want=%b", i, MisalignW, e_mis); end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
    model_clear();
    test_reset();
    init_memory();
    test_reset_midstream();
    test_loads();
    test_misalign();
    test_stall();
    test_flush_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
